// File: rtl/id_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// id_stage : LA32R decode stage - operand forwarding, load-use stall, branches
// Rev 1.0
// ----------------------------------------------------------------------------
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         IDsignal_valid,
  input  logic [63:0]  ID_signal,
  output logic         ID_allowin,
  output logic [32:0]  br_signal,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  // each is {valid, rf_we, is_load, dest[4:0], result[31:0]}: five fields, 40 bits
  input  logic [39:0]  EX_fwd,
  input  logic [39:0]  MEM_fwd,
  input  logic [39:0]  WB_fwd,
  input  logic         EX_allowin,
  output logic         EXsignal_valid,
  output logic [139:0] EX_signal
);

  localparam logic [16:0] OP_ADD_W   = 17'h00020;
  localparam logic [16:0] OP_SUB_W   = 17'h00022;
  localparam logic [16:0] OP_SLT     = 17'h00024;
  localparam logic [16:0] OP_SLTU    = 17'h00025;
  localparam logic [16:0] OP_AND     = 17'h00029;
  localparam logic [16:0] OP_OR      = 17'h0002a;
  localparam logic [16:0] OP_XOR     = 17'h0002b;
  localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
  localparam logic [9:0]  OP_LD_W    = 10'h0a2;
  localparam logic [9:0]  OP_ST_W    = 10'h0a6;
  localparam logic [6:0]  OP_LU12I_W = 7'h0a;
  localparam logic [5:0]  OP_JIRL    = 6'h13;
  localparam logic [5:0]  OP_B       = 6'h14;
  localparam logic [5:0]  OP_BL      = 6'h15;
  localparam logic [5:0]  OP_BEQ     = 6'h16;
  localparam logic [5:0]  OP_BNE     = 6'h17;

  localparam logic [3:0]  ALU_ADD  = 4'd0;
  localparam logic [3:0]  ALU_SUB  = 4'd1;
  localparam logic [3:0]  ALU_SLT  = 4'd2;
  localparam logic [3:0]  ALU_SLTU = 4'd3;
  localparam logic [3:0]  ALU_AND  = 4'd4;
  localparam logic [3:0]  ALU_OR   = 4'd5;
  localparam logic [3:0]  ALU_XOR  = 4'd6;
  localparam logic [3:0]  ALU_PASS = 4'd7;

  logic        r_id_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  logic        w_readygo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_valid <= 1'b0;
      r_inst     <= 32'd0;
      r_pc       <= RESET_PC;
    end else begin
      if (ID_allowin)
        r_id_valid <= IDsignal_valid;
      if (IDsignal_valid && ID_allowin)
        {r_inst, r_pc} <= ID_signal;
    end
  end

  logic [4:0]  w_rd, w_rj, w_rk;
  logic [11:0] w_si12;
  logic [19:0] w_si20;
  logic [15:0] w_offs16;
  logic [25:0] w_offs26;

  assign w_rd     = r_inst[4:0];
  assign w_rj     = r_inst[9:5];
  assign w_rk     = r_inst[14:10];
  assign w_si12   = r_inst[21:10];
  assign w_si20   = r_inst[24:5];
  assign w_offs16 = r_inst[25:10];
  assign w_offs26 = {r_inst[9:0], r_inst[25:10]};

  logic w_add, w_sub, w_slt, w_sltu, w_and, w_or, w_xor;
  logic w_addi, w_ld, w_st, w_lu12i;
  logic w_jirl, w_b, w_bl, w_beq, w_bne;
  logic w_is_3r, w_use1, w_use2, w_writer;

  assign w_add   = (r_inst[31:15] == OP_ADD_W);
  assign w_sub   = (r_inst[31:15] == OP_SUB_W);
  assign w_slt   = (r_inst[31:15] == OP_SLT);
  assign w_sltu  = (r_inst[31:15] == OP_SLTU);
  assign w_and   = (r_inst[31:15] == OP_AND);
  assign w_or    = (r_inst[31:15] == OP_OR);
  assign w_xor   = (r_inst[31:15] == OP_XOR);
  assign w_addi  = (r_inst[31:22] == OP_ADDI_W);
  assign w_ld    = (r_inst[31:22] == OP_LD_W);
  assign w_st    = (r_inst[31:22] == OP_ST_W);
  assign w_lu12i = (r_inst[31:25] == OP_LU12I_W);
  assign w_jirl  = (r_inst[31:26] == OP_JIRL);
  assign w_b     = (r_inst[31:26] == OP_B);
  assign w_bl    = (r_inst[31:26] == OP_BL);
  assign w_beq   = (r_inst[31:26] == OP_BEQ);
  assign w_bne   = (r_inst[31:26] == OP_BNE);

  assign w_is_3r  = w_add | w_sub | w_slt | w_sltu | w_and | w_or | w_xor;
  assign w_use1   = w_is_3r | w_addi | w_ld | w_st | w_jirl | w_beq | w_bne;
  assign w_use2   = w_is_3r | w_st | w_beq | w_bne;
  assign w_writer = w_is_3r | w_addi | w_ld | w_lu12i | w_bl | w_jirl;

  assign rf_raddr1 = w_rj;
  assign rf_raddr2 = (w_beq | w_bne | w_st) ? w_rd : w_rk;

  function automatic logic fwd_match(input logic [4:0] addr, input logic used,
                                     input logic vld, input logic we,
                                     input logic [4:0] dest);
    return used && (addr != 5'd0) && vld && we && (dest == addr);
  endfunction

  logic w_ex_hit1, w_mem_hit1, w_wb_hit1;
  logic w_ex_hit2, w_mem_hit2, w_wb_hit2;
  logic [31:0] w_val1, w_val2;

  assign w_ex_hit1  = fwd_match(rf_raddr1, w_use1, EX_fwd[39],  EX_fwd[38],  EX_fwd[36:32]);
  assign w_mem_hit1 = fwd_match(rf_raddr1, w_use1, MEM_fwd[39], MEM_fwd[38], MEM_fwd[36:32]);
  assign w_wb_hit1  = fwd_match(rf_raddr1, w_use1, WB_fwd[39],  WB_fwd[38],  WB_fwd[36:32]);
  assign w_ex_hit2  = fwd_match(rf_raddr2, w_use2, EX_fwd[39],  EX_fwd[38],  EX_fwd[36:32]);
  assign w_mem_hit2 = fwd_match(rf_raddr2, w_use2, MEM_fwd[39], MEM_fwd[38], MEM_fwd[36:32]);
  assign w_wb_hit2  = fwd_match(rf_raddr2, w_use2, WB_fwd[39],  WB_fwd[38],  WB_fwd[36:32]);

  // later assignments win, giving EX > MEM > WB > register file
  always_comb begin
    w_val1 = rf_rdata1;
    if (w_wb_hit1)  w_val1 = WB_fwd[31:0];
    if (w_mem_hit1) w_val1 = MEM_fwd[31:0];
    if (w_ex_hit1)  w_val1 = EX_fwd[31:0];
    w_val2 = rf_rdata2;
    if (w_wb_hit2)  w_val2 = WB_fwd[31:0];
    if (w_mem_hit2) w_val2 = MEM_fwd[31:0];
    if (w_ex_hit2)  w_val2 = EX_fwd[31:0];
  end

  // a load still in EX has no data yet; MEM/WB results are always final
  assign w_readygo = !(EX_fwd[37] && (w_ex_hit1 || w_ex_hit2));

  logic w_unused_load_bits;
  assign w_unused_load_bits = ^{MEM_fwd[37], WB_fwd[37]};

  logic [3:0]  w_alu_op;
  logic [31:0] w_src1, w_src2;

  always_comb begin
    w_alu_op = ALU_ADD;
    w_src1   = w_val1;
    w_src2   = w_val2;
    if (w_sub)  w_alu_op = ALU_SUB;
    if (w_slt)  w_alu_op = ALU_SLT;
    if (w_sltu) w_alu_op = ALU_SLTU;
    if (w_and)  w_alu_op = ALU_AND;
    if (w_or)   w_alu_op = ALU_OR;
    if (w_xor)  w_alu_op = ALU_XOR;
    if (w_addi || w_ld || w_st)
      w_src2 = {{20{w_si12[11]}}, w_si12};
    if (w_lu12i) begin
      w_src2   = {w_si20, 12'd0};
      w_alu_op = ALU_PASS;
    end
    if (w_bl || w_jirl) begin
      w_src1 = r_pc;
      w_src2 = 32'd4;
    end
  end

  logic [4:0]  w_dest;
  logic        w_rf_we;
  logic [31:0] w_off16, w_off26, w_br_target;
  logic        w_eq, w_br_taken;

  assign w_dest  = w_bl ? 5'd1 : w_rd;
  assign w_rf_we = w_writer && (w_dest != 5'd0);

  assign w_off16 = {{14{w_offs16[15]}}, w_offs16, 2'b00};
  assign w_off26 = {{4{w_offs26[25]}}, w_offs26, 2'b00};
  assign w_br_target = w_jirl       ? (w_val1 + w_off16) :
                       (w_b | w_bl) ? (r_pc + w_off26)   :
                                      (r_pc + w_off16);
  assign w_eq       = (w_val1 == w_val2);
  assign w_br_taken = r_id_valid && w_readygo &&
                      (w_b | w_bl | w_jirl | (w_beq & w_eq) | (w_bne & ~w_eq));

  assign br_signal      = {w_br_taken, w_br_target};
  assign ID_allowin     = !r_id_valid || (w_readygo && EX_allowin);
  assign EXsignal_valid = r_id_valid && w_readygo;
  assign EX_signal      = {r_pc, w_src1, w_src2, w_alu_op, w_st, w_ld, w_rf_we,
                           w_dest, w_val2};

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_id_stage : directed vector table plus stall / backpressure / reset sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [31:0] PC0 = 32'h1c000000;
  localparam logic [31:0] I_ADD = 32'h00100c85;   // add.w r5,r4,r3
  localparam logic [31:0] I_OR  = 32'h00150c85;   // or    r5,r4,r3
  localparam logic [31:0] I_BL  = 32'h54001000;   // bl    +4 words

  logic         clk = 1'b0;
  logic         reset;
  logic         IDsignal_valid;
  logic [63:0]  ID_signal;
  logic         ID_allowin;
  logic [32:0]  br_signal;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [39:0]  EX_fwd, MEM_fwd, WB_fwd;
  logic         EX_allowin;
  logic         EXsignal_valid;
  logic [139:0] EX_signal;

  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  id_stage dut (
    .clk(clk), .reset(reset),
    .IDsignal_valid(IDsignal_valid), .ID_signal(ID_signal), .ID_allowin(ID_allowin),
    .br_signal(br_signal),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .EX_fwd(EX_fwd), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd),
    .EX_allowin(EX_allowin), .EXsignal_valid(EXsignal_valid), .EX_signal(EX_signal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]  inst;
    logic [31:0]  pc;
    logic [4:0]   ra;
    logic [31:0]  va;
    logic [4:0]   rb;
    logic [31:0]  vb;
    logic [39:0]  ex, mem, wb;
    logic         exv;
    logic [32:0]  br;
    logic         brt;
    logic [139:0] bun;
    logic [139:0] msk;
  } vec_t;

  vec_t vq[$];

  function automatic logic [39:0] fw(input logic v, input logic we, input logic ld,
                                     input logic [4:0] d, input logic [31:0] r);
    return {v, we, ld, d, r};
  endfunction

  function automatic logic [139:0] bun(input logic [31:0] pc, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [3:0] op,
                                       input logic mwe, input logic rfm, input logic we,
                                       input logic [4:0] dst, input logic [31:0] st);
    return {pc, s1, s2, op, mwe, rfm, we, dst, st};
  endfunction

  // pc, mem_we, res_from_mem and rf_we are always checked
  function automatic logic [139:0] msk(input logic s1, input logic s2, input logic op,
                                       input logic dst, input logic st);
    return {32'hffffffff, {32{s1}}, {32{s2}}, {4{op}}, 3'b111, {5{dst}}, {32{st}}};
  endfunction

  task automatic addv(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [4:0] ra, input logic [31:0] va,
                      input logic [4:0] rb, input logic [31:0] vb,
                      input logic [39:0] ex, input logic [39:0] mem, input logic [39:0] wb,
                      input logic exv, input logic [32:0] br, input logic brt,
                      input logic [139:0] b, input logic [139:0] m);
    vec_t v;
    v.inst = inst; v.pc = pc; v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
    v.ex = ex; v.mem = mem; v.wb = wb; v.exv = exv; v.br = br; v.brt = brt;
    v.bun = b; v.msk = m;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp,
                     input logic [139:0] m);
    n_cmp++;
    if ((act & m) !== (exp & m)) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act & m, exp & m);
    end
  endtask

  task automatic set_regs(input logic [4:0] a, input logic [31:0] va,
                          input logic [4:0] b, input logic [31:0] vb);
    for (int k = 0; k < 32; k++) regs[k] = 32'h100 + k;
    regs[a] = va;
    regs[b] = vb;
    regs[0] = 32'd0;
  endtask

  localparam logic [139:0] M1  = 140'd1;
  localparam logic [139:0] MBT = 140'h1_ffff_ffff;
  localparam logic [139:0] MBN = 140'h1_0000_0000;

  initial begin
    logic [139:0] std_m, pc_m;
    std_m = msk(1, 1, 1, 1, 0);
    pc_m  = msk(0, 0, 0, 0, 0);

    // 3R ALU ops
    addv(I_ADD, PC0, 4, 7, 3, 9, 0, 0, 0, 1, 33'd0, 0, bun(PC0, 7, 9, 0, 0, 0, 1, 5, 0), std_m);
    addv(I_OR,  PC0, 4, 7, 3, 9, 0, 0, 0, 1, 33'd0, 0, bun(PC0, 7, 9, 5, 0, 0, 1, 5, 0), std_m);
    addv(32'h00110826, PC0, 1, 20, 2, 5, 0, 0, 0, 1, 33'd0, 0, bun(PC0, 20, 5, 1, 0, 0, 1, 6, 0), std_m);
    addv(32'h00122507, PC0, 8, 32'h80000000, 9, 1, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'h80000000, 1, 2, 0, 0, 1, 7, 0), std_m);
    addv(32'h0012a507, PC0, 8, 32'h80000000, 9, 1, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'h80000000, 1, 3, 0, 0, 1, 7, 0), std_m);
    addv(32'h0014f7df, PC0, 30, 32'hf0f0, 29, 32'hff00, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'hf0f0, 32'hff00, 4, 0, 0, 1, 31, 0), std_m);
    addv(32'h00158c41, PC0, 2, 32'haa, 3, 32'h0f, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'haa, 32'h0f, 6, 0, 0, 1, 1, 0), std_m);
    // immediate forms, loads, stores
    addv(32'h02bffc22, PC0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'h10, 32'hffffffff, 0, 0, 0, 1, 2, 0), std_m);
    addv(32'h28802083, PC0, 4, 32'h1000, 0, 0, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'h1000, 8, 0, 0, 1, 1, 3, 0), std_m);
    addv(32'h29bff0c5, PC0, 6, 32'h2000, 5, 32'hdeadbeef, 0, 0, 0, 1, 33'd0, 0,
         bun(PC0, 32'h2000, 32'hfffffffc, 0, 1, 0, 0, 0, 32'hdeadbeef), msk(1, 1, 1, 0, 1));
    // lu12i with a load in EX on its (unused) rj field: must not stall
    addv(32'h142468a9, PC0, 0, 0, 0, 0, fw(1, 1, 1, 5, 32'hbad), 0, 0, 1, 33'd0, 0,
         bun(PC0, 0, 32'h12345000, 7, 0, 0, 1, 9, 0), msk(0, 1, 1, 1, 0));
    // branches and jumps
    addv(I_BL, PC0, 0, 0, 0, 0, 0, 0, 0, 1, {1'b1, 32'h1c000010}, 1,
         bun(PC0, PC0, 4, 0, 0, 0, 1, 1, 0), std_m);
    addv(32'h4c000020, 32'h1c000040, 1, 32'h1c000100, 0, 0, 0, 0, 0, 1, {1'b1, 32'h1c000100}, 1,
         bun(32'h1c000040, 32'h1c000040, 4, 0, 0, 0, 0, 0, 0), std_m);
    addv(32'h4ffffc40, 32'h1c000050, 2, 0, 0, 0, 0, fw(1, 1, 0, 2, 32'h1c000200), 0, 1,
         {1'b1, 32'h1c0001fc}, 1, bun(32'h1c000050, 32'h1c000050, 4, 0, 0, 0, 0, 0, 0), std_m);
    addv(32'h58002022, 32'h1c000010, 1, 3, 2, 3, 0, 0, 0, 1, {1'b1, 32'h1c000030}, 1,
         bun(32'h1c000010, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);
    addv(32'h58002022, 32'h1c000010, 1, 3, 2, 4, 0, 0, 0, 1, 33'd0, 0,
         bun(32'h1c000010, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);
    addv(32'h5ffff822, 32'h1c000100, 1, 1, 2, 2, 0, 0, 0, 1, {1'b1, 32'h1c0000f8}, 1,
         bun(32'h1c000100, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);
    addv(32'h5ffff822, 32'h1c000100, 1, 5, 2, 9, fw(1, 1, 0, 2, 5), 0, 0, 1, 33'd0, 0,
         bun(32'h1c000100, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);
    addv(32'h53ffffff, PC0, 0, 0, 0, 0, 0, 0, 0, 1, {1'b1, 32'h1bfffffc}, 1,
         bun(PC0, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);
    // forwarding priority and qualifiers
    addv(I_ADD, PC0, 4, 32'h77, 3, 9, fw(1, 1, 0, 4, 1), fw(1, 1, 0, 4, 2), fw(1, 1, 0, 4, 3),
         1, 33'd0, 0, bun(PC0, 1, 9, 0, 0, 0, 1, 5, 0), std_m);
    addv(I_ADD, PC0, 4, 32'h77, 3, 9, fw(1, 1, 0, 0, 1), fw(1, 1, 0, 4, 2), fw(1, 1, 0, 4, 3),
         1, 33'd0, 0, bun(PC0, 2, 9, 0, 0, 0, 1, 5, 0), std_m);
    addv(I_ADD, PC0, 4, 32'h77, 3, 9, fw(1, 0, 0, 4, 1), fw(0, 1, 0, 4, 2), fw(1, 1, 0, 4, 3),
         1, 33'd0, 0, bun(PC0, 3, 9, 0, 0, 0, 1, 5, 0), std_m);
    addv(I_ADD, PC0, 4, 7, 3, 9, 0, 0, fw(1, 1, 0, 3, 32'h33),
         1, 33'd0, 0, bun(PC0, 7, 32'h33, 0, 0, 0, 1, 5, 0), std_m);
    addv(I_ADD, PC0, 4, 7, 3, 9, fw(1, 1, 1, 3, 0), 0, 0, 0, 33'd0, 0, 140'd0, 140'd0);
    addv(32'h00100c05, PC0, 0, 0, 3, 9, fw(1, 1, 1, 0, 32'hff), 0, 0, 1, 33'd0, 0,
         bun(PC0, 0, 9, 0, 0, 0, 1, 5, 0), std_m);
    // rd = r0 suppresses the write; unknown opcode is a bubble
    addv(32'h00100c80, PC0, 4, 7, 3, 9, 0, 0, 0, 1, 33'd0, 0, bun(PC0, 7, 9, 0, 0, 0, 0, 0, 0), std_m);
    addv(32'hffffffff, PC0, 0, 0, 0, 0, 0, 0, 0, 1, 33'd0, 0, bun(PC0, 0, 0, 0, 0, 0, 0, 0, 0), pc_m);

    // reset state
    set_regs(4, 7, 3, 9);
    reset = 1'b1; IDsignal_valid = 1'b1; ID_signal = {I_ADD, PC0};
    EX_fwd = '0; MEM_fwd = '0; WB_fwd = '0; EX_allowin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst allowin", ID_allowin, 1, M1);
    chk("rst br_taken", br_signal, 0, MBN);
    chk("rst exv", EXsignal_valid, 0, M1);
    chk("rst pc", EX_signal, bun(PC0, 0, 0, 0, 0, 0, 0, 0, 0), 140'hffffffff << 108);
    reset = 1'b0; IDsignal_valid = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      set_regs(vq[i].ra, vq[i].va, vq[i].rb, vq[i].vb);
      EX_fwd = vq[i].ex; MEM_fwd = vq[i].mem; WB_fwd = vq[i].wb;
      IDsignal_valid = 1'b1; ID_signal = {vq[i].inst, vq[i].pc};
      @(posedge clk);
      @(negedge clk);
      IDsignal_valid = 1'b0;
      chk($sformatf("v%0d exv", i), EXsignal_valid, vq[i].exv, M1);
      chk($sformatf("v%0d allowin", i), ID_allowin, vq[i].exv, M1);
      chk($sformatf("v%0d br", i), br_signal, vq[i].br, vq[i].brt ? MBT : MBN);
      if (vq[i].exv)
        chk($sformatf("v%0d bundle", i), EX_signal, vq[i].bun, vq[i].msk);
      EX_fwd = '0; MEM_fwd = '0; WB_fwd = '0;
      @(posedge clk);
    end

    // load-use: stall one cycle, then take the loaded value from MEM
    @(negedge clk);
    set_regs(4, 7, 3, 9);
    EX_fwd = fw(1, 1, 1, 4, 0);
    IDsignal_valid = 1'b1; ID_signal = {I_ADD, 32'h1c000100};
    @(posedge clk);
    @(negedge clk);
    chk("lu stall exv", EXsignal_valid, 0, M1);
    chk("lu stall allowin", ID_allowin, 0, M1);
    chk("lu stall br", br_signal, 0, MBN);
    ID_signal = {I_OR, 32'h1c000104};
    @(posedge clk);
    #1;
    EX_fwd = '0; MEM_fwd = fw(1, 1, 1, 4, 32'h55);
    @(negedge clk);
    chk("lu release exv", EXsignal_valid, 1, M1);
    chk("lu release allowin", ID_allowin, 1, M1);
    chk("lu release bundle", EX_signal, bun(32'h1c000100, 32'h55, 9, 0, 0, 0, 1, 5, 0), msk(1, 1, 1, 1, 0));
    @(posedge clk);
    #1;
    MEM_fwd = '0; IDsignal_valid = 1'b0;
    @(negedge clk);
    chk("lu next bundle", EX_signal, bun(32'h1c000104, 7, 9, 5, 0, 0, 1, 5, 0), msk(1, 1, 1, 1, 0));
    chk("lu next exv", EXsignal_valid, 1, M1);
    @(posedge clk);

    // backpressure holds a taken bl, then reset mid-hold
    @(negedge clk);
    set_regs(0, 0, 0, 0);
    EX_allowin = 1'b0;
    IDsignal_valid = 1'b1; ID_signal = {I_BL, PC0};
    @(posedge clk);
    #1;
    ID_signal = {I_ADD, 32'h1c000004};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d exv", k), EXsignal_valid, 1, M1);
      chk($sformatf("bp%0d allowin", k), ID_allowin, 0, M1);
      chk($sformatf("bp%0d br", k), br_signal, {1'b1, 32'h1c000010}, MBT);
      chk($sformatf("bp%0d bundle", k), EX_signal, bun(PC0, PC0, 4, 0, 0, 0, 1, 1, 0), msk(1, 1, 1, 1, 0));
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("bp reset exv", EXsignal_valid, 0, M1);
    chk("bp reset allowin", ID_allowin, 1, M1);
    chk("bp reset br", br_signal, 0, MBN);
    @(negedge clk);
    reset = 1'b0; IDsignal_valid = 1'b0; EX_allowin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post reset exv", EXsignal_valid, 0, M1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
